// File: rtl/seu_count_readout.sv
// Snapshots an SEU counter on readReq and shifts it out MSB first, one bit per cycle.
// First bit 1 cycle after the request edge; readReq is ignored while a frame is in flight.
module seu_count_readout #(
  parameter int SEUCNTWIDTH   = 8,
  parameter int CLEAR_ON_READ = 1,
  parameter int FRAMECNTWIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEUCNTWIDTH-1:0]   seuCount,
  output logic                     seuCountRst,
  input  logic                     readReq,
  output logic                     busy,
  output logic                     sdo,
  output logic                     sdoValid,
  output logic                     sdoLast,
  output logic                     saturated,
  output logic [FRAMECNTWIDTH-1:0] frameCount
);

  localparam int IDXW = (SEUCNTWIDTH > 1) ? $clog2(SEUCNTWIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SEUCNTWIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SEUCNTWIDTH-1:0] snapshot;
  logic [IDXW-1:0]        index;
  logic [IDXW-1:0]        bit_sel;
  logic                   load;
  logic                   frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    sdo        = 1'b0;
    sdoValid   = 1'b0;
    sdoLast    = 1'b0;
    bit_sel    = LAST_IDX - index;
    case (state)
      IDLE: begin
        if (readReq) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        sdoValid = 1'b1;
        sdo      = snapshot[bit_sel];
        if (index == LAST_IDX) begin
          sdoLast    = 1'b1;
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot is frozen for the whole frame, so seuCount may change freely while shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot    <= '0;
      index       <= '0;
      seuCountRst <= 1'b0;
      saturated   <= 1'b0;
      frameCount  <= '0;
    end else begin
      seuCountRst <= load && (CLEAR_ON_READ != 0);
      if (load) begin
        snapshot  <= seuCount;
        index     <= '0;
        saturated <= &seuCount;
      end else if (state == SHIFT) begin
        index <= index + IDXW'(1);
      end
      if (frame_done) begin
        frameCount <= frameCount + FRAMECNTWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_seu_count_readout.sv
// Directed bench for seu_count_readout: expected serial bits are queued when a
// snapshot is requested and popped whenever a DUT asserts sdoValid.
module tb_seu_count_readout;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_bc;
  logic [7:0] cnt_a, cnt_b;
  logic [0:0] cnt_c;
  logic       req_a, req_b, req_c;
  logic       rstout_a, busy_a, sdo_a, vld_a, last_a, sat_a;
  logic       rstout_b, busy_b, sdo_b, vld_b, last_b, sat_b;
  logic       rstout_c, busy_c, sdo_c, vld_c, last_c, sat_c;
  logic [3:0] fc_a, fc_b, fc_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int pulses_c = 0;
  int p0;

  seu_count_readout #(.SEUCNTWIDTH(8), .CLEAR_ON_READ(1), .FRAMECNTWIDTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .seuCount(cnt_a), .seuCountRst(rstout_a), .readReq(req_a),
    .busy(busy_a), .sdo(sdo_a), .sdoValid(vld_a), .sdoLast(last_a),
    .saturated(sat_a), .frameCount(fc_a));

  seu_count_readout #(.SEUCNTWIDTH(8), .CLEAR_ON_READ(0), .FRAMECNTWIDTH(4)) dut_b (
    .clk(clk), .rst(rst_bc), .seuCount(cnt_b), .seuCountRst(rstout_b), .readReq(req_b),
    .busy(busy_b), .sdo(sdo_b), .sdoValid(vld_b), .sdoLast(last_b),
    .saturated(sat_b), .frameCount(fc_b));

  seu_count_readout #(.SEUCNTWIDTH(1), .CLEAR_ON_READ(1), .FRAMECNTWIDTH(4)) dut_c (
    .clk(clk), .rst(rst_bc), .seuCount(cnt_c), .seuCountRst(rstout_c), .readReq(req_c),
    .busy(busy_c), .sdo(sdo_c), .sdoValid(vld_c), .sdoLast(last_c),
    .saturated(sat_c), .frameCount(fc_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int ln, input string tag, input logic v, input logic d, input logic l);
    exp_t e;
    int   n;
    n = (ln == 0) ? q_a.size() : (ln == 1) ? q_b.size() : q_c.size();
    if (v === 1'b1) begin
      checks++;
      assert (n > 0) else begin
        errors++;
        $error("FAIL %s_unexpected_bit: observed sdoValid 1 expected no pending bit", tag);
      end
      if (n > 0) begin
        case (ln)
          0:       e = q_a.pop_front();
          1:       e = q_b.pop_front();
          default: e = q_c.pop_front();
        endcase
        chk({tag, "_sdo"}, d, e.b);
        chk({tag, "_last"}, l, e.last);
      end
    end else begin
      chk({tag, "_valid_known"}, v, 0);
      chk({tag, "_idle_sdo"}, d, 0);
      chk({tag, "_idle_last"}, l, 0);
    end
  endtask

  // Advance one clock and compare every lane's serial output against its queue.
  task automatic cycle();
    @(posedge clk);
    #1;
    lane(0, "a", vld_a, sdo_a, last_a);
    lane(1, "b", vld_b, sdo_b, last_b);
    lane(2, "c", vld_c, sdo_c, last_c);
    if (rstout_a === 1'b1) pulses_a++;
    if (rstout_b === 1'b1) pulses_b++;
    if (rstout_c === 1'b1) pulses_c++;
  endtask

  task automatic push_a(input logic [7:0] v, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) q_a.push_back('{b: v[i], last: (i == 0)});
  endtask

  task automatic push_b(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) q_b.push_back('{b: v[i], last: (i == 0)});
  endtask

  task automatic push_c(input logic v);
    q_c.push_back('{b: v, last: 1'b1});
  endtask

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    cnt_a = '0; cnt_b = '0; cnt_c = '0;
    repeat (2) cycle();
    chk("rst_valid", vld_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_sdo", sdo_a, 0);
    chk("rst_clr", rstout_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_fc", fc_a, 0);
    chk("rst_fc_b", fc_b, 0);
    chk("rst_busy_c", busy_c, 0);
    rst_a = 1'b0; rst_bc = 1'b0;
    cycle();

    // abort a frame with reset while the 4th bit is on sdo
    cnt_a = 8'hFF; req_a = 1'b1; push_a(8'hFF, 4);
    cycle();
    chk("abort_clr_pulse", rstout_a, 1);
    chk("abort_sat", sat_a, 1);
    req_a = 1'b0;
    repeat (3) cycle();
    chk("abort_bit4_valid", vld_a, 1);
    rst_a = 1'b1;
    cycle();
    chk("abort_valid", vld_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_fc", fc_a, 0);
    chk("abort_sat_cleared", sat_a, 0);
    chk("abort_clr", rstout_a, 0);
    rst_a = 1'b0;
    repeat (2) cycle();
    chk("abort_pulse_total", pulses_a, 1);
    chk("abort_queue", q_a.size(), 0);

    // 0xA5 single frame
    cnt_a = 8'hA5; req_a = 1'b1; push_a(8'hA5, 8);
    cycle();
    chk("a5_clr_pulse", rstout_a, 1);
    chk("a5_busy", busy_a, 1);
    chk("a5_sat", sat_a, 0);
    req_a = 1'b0;
    cycle();
    chk("a5_clr_one_cycle", rstout_a, 0);
    repeat (6) cycle();
    chk("a5_last", last_a, 1);
    chk("a5_fc_before_end", fc_a, 0);
    cycle();
    chk("a5_end_valid", vld_a, 0);
    chk("a5_end_busy", busy_a, 0);
    chk("a5_fc", fc_a, 1);
    chk("a5_queue", q_a.size(), 0);
    chk("a5_pulse_total", pulses_a, 2);

    // saturation: all-ones then 0x03
    cnt_a = 8'hFF; req_a = 1'b1; push_a(8'hFF, 8);
    cycle();
    chk("sat_set", sat_a, 1);
    req_a = 1'b0;
    repeat (8) cycle();
    chk("sat_sticky", sat_a, 1);
    chk("sat_fc", fc_a, 2);
    cnt_a = 8'h03; req_a = 1'b1; push_a(8'h03, 8);
    cycle();
    chk("sat_clear", sat_a, 0);
    req_a = 1'b0;
    repeat (8) cycle();
    chk("sat_fc2", fc_a, 3);

    // readReq held for 30 cycles: a new snapshot every 9 cycles, seuCount changing each cycle
    p0 = pulses_a;
    req_a = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      cnt_a = 8'(e * 7 + 3);
      if ((e - 1) % 9 == 0) push_a(cnt_a, 8);
      cycle();
      chk("hold_valid", vld_a, ((e - 1) % 9) != 8);
      chk("hold_busy", busy_a, ((e - 1) % 9) != 8);
    end
    req_a = 1'b0; cnt_a = '0;
    repeat (5) cycle();
    chk("hold_last", last_a, 1);
    cycle();
    chk("hold_end_valid", vld_a, 0);
    chk("hold_fc", fc_a, 7);
    chk("hold_queue", q_a.size(), 0);
    chk("hold_pulses", pulses_a - p0, 4);

    // seuCount toggling during the shift must not disturb the frame
    cnt_a = 8'h5A; req_a = 1'b1; push_a(8'h5A, 8);
    cycle();
    req_a = 1'b0;
    repeat (7) begin
      cnt_a = ~cnt_a;
      cycle();
    end
    cycle();
    chk("toggle_fc", fc_a, 8);
    chk("toggle_queue", q_a.size(), 0);

    // no clear-on-read, 17 frames wrap the 4-bit frame counter
    for (int k = 0; k < 17; k++) begin
      cnt_b = 8'(k * 29 + 17); req_b = 1'b1; push_b(cnt_b);
      cycle();
      req_b = 1'b0;
      repeat (8) cycle();
      chk("nc_fc", fc_b, (k + 1) % 16);
    end
    chk("nc_fc_wrap", fc_b, 1);
    chk("nc_no_clear", pulses_b, 0);
    chk("nc_queue", q_b.size(), 0);

    // one-bit counter: single-cycle frames
    cnt_c = 1'b1; req_c = 1'b1; push_c(1'b1);
    cycle();
    chk("w1_valid", vld_c, 1);
    chk("w1_last", last_c, 1);
    chk("w1_busy", busy_c, 1);
    chk("w1_sat", sat_c, 1);
    chk("w1_clr", rstout_c, 1);
    req_c = 1'b0;
    cycle();
    chk("w1_end_valid", vld_c, 0);
    chk("w1_fc", fc_c, 1);
    cnt_c = 1'b0; req_c = 1'b1; push_c(1'b0);
    cycle();
    chk("w1_sat_clear", sat_c, 0);
    req_c = 1'b0;
    cycle();
    chk("w1_fc2", fc_c, 2);
    chk("w1_pulses", pulses_c, 2);
    chk("w1_queue", q_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
